// File: rtl/systolic_mac_array_if.sv
// Host-side bus of systolic_mac_array: beat stream, preload/readout port and status.
// master drives stimulus (host), slave is the array.
interface systolic_mac_array_if #(
   parameter int unsigned BITS_AB = 8,
   parameter int unsigned BITS_C  = 16,
   parameter int unsigned DIM     = 4
);
   localparam int unsigned ROW_W = (DIM > 1) ? $clog2(DIM) : 1;

   logic                   clr;
   logic                   in_valid;
   logic                   in_last;
   logic                   in_ready;
   logic [DIM*BITS_AB-1:0] A_flat;
   logic [DIM*BITS_AB-1:0] B_flat;
   logic                   WrEn;
   logic [DIM*BITS_C-1:0]  Cin_flat;
   logic [ROW_W-1:0]       Crow;
   logic [DIM*BITS_C-1:0]  Cout;
   logic                   busy;
   logic                   done;

   modport master (
      output clr, in_valid, in_last, A_flat, B_flat, WrEn, Cin_flat, Crow,
      input  in_ready, Cout, busy, done
   );

   modport slave (
      input  clr, in_valid, in_last, A_flat, B_flat, WrEn, Cin_flat, Crow,
      output in_ready, Cout, busy, done
   );
endinterface

// File: rtl/systolic_mac_array.sv
// DIM x DIM output-stationary signed MAC array with input skew, stream/drain FSM and row readout.
// Optional macro SYSTOLIC_MAC_SAT_EN: saturating accumulate instead of two's-complement wrap.
module systolic_mac_array #(
   parameter int unsigned BITS_AB = 8,
   parameter int unsigned BITS_C  = 16,
   parameter int unsigned DIM     = 4
) (
   input logic                  clk,
   input logic                  rst,
   systolic_mac_array_if.slave  bus
);
   localparam int unsigned ROW_W      = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int unsigned CNT_W      = (DIM > 1) ? $clog2(2*DIM) : 1;
   localparam int unsigned DRAIN_LAST = (DIM > 1) ? 2*DIM - 3 : 0;
   localparam int unsigned PROD_W     = 2*BITS_AB;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   drain_cnt;
   logic               in_ready_q;
   logic               busy_q;
   logic               done_q;
   logic [DIM*BITS_C-1:0] cout_q;

   logic accept;
   logic draining;
   logic idle_like;
   logic adv;
   logic clr_go;
   logic row_ok;
   logic wr_go;
   logic drain_end;

   assign accept    = bus.in_valid && in_ready_q;
   assign draining  = (state == DRAIN);
   assign idle_like = (state == IDLE) || (state == DONE);
   assign adv       = accept || draining;
   assign clr_go    = bus.clr && idle_like;
   assign row_ok    = (32'(bus.Crow) < DIM);
   assign wr_go     = bus.WrEn && idle_like && !bus.clr && row_ok;
   assign drain_end = (drain_cnt == CNT_W'(DRAIN_LAST));

   assign bus.in_ready = in_ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.Cout     = cout_q;

   function automatic state_t next_state(input state_t s, input logic beat,
                                         input logic last, input logic clr_in,
                                         input logic d_end);
      state_t ns;
      ns = s;
      case (s)
         IDLE, DONE: begin
            if (beat) begin
               if (!last)          ns = STREAM;
               else if (DIM == 1)  ns = DONE;
               else                ns = DRAIN;
            end else if (clr_in) begin
               ns = IDLE;
            end
         end
         STREAM: if (beat && last) ns = (DIM == 1) ? DONE : DRAIN;
         DRAIN:  if (d_end) ns = DONE;
         default: ns = IDLE;
      endcase
      return ns;
   endfunction

   assign state_nx = next_state(state, accept, bus.in_last, bus.clr, drain_end);

   // Sequencer with status outputs registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         drain_cnt  <= '0;
         in_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_nx;
         drain_cnt  <= (state_nx == DRAIN && state == DRAIN) ? drain_cnt + CNT_W'(1) : '0;
         in_ready_q <= (state_nx != DRAIN);
         busy_q     <= (state_nx == STREAM) || (state_nx == DRAIN);
         done_q     <= (state_nx == DONE);
      end
   end

   function automatic logic signed [BITS_C-1:0] mac(input logic signed [BITS_C-1:0]  c,
                                                    input logic signed [BITS_AB-1:0] a,
                                                    input logic signed [BITS_AB-1:0] b);
      logic signed [PROD_W-1:0] p;
      logic signed [BITS_C-1:0] pc;
`ifdef SYSTOLIC_MAC_SAT_EN
      logic signed [BITS_C:0]   s;
`endif
      p  = PROD_W'(a) * PROD_W'(b);
      pc = BITS_C'(p);
`ifdef SYSTOLIC_MAC_SAT_EN
      s = (BITS_C+1)'(c) + (BITS_C+1)'(pc);
      if (s[BITS_C] != s[BITS_C-1])
         return s[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
      return s[BITS_C-1:0];
`else
      return c + pc;
`endif
   endfunction

   logic signed [BITS_AB-1:0] a_edge [DIM];
   logic signed [BITS_AB-1:0] b_edge [DIM];
   logic signed [BITS_AB-1:0] a_sk   [DIM];
   logic signed [BITS_AB-1:0] b_sk   [DIM];

   // Zeros enter the array edge while draining so stale beats never re-accumulate
   always_comb begin
      for (int unsigned i = 0; i < DIM; i++) begin
         a_edge[i] = draining ? '0 : bus.A_flat[i*BITS_AB +: BITS_AB];
         b_edge[i] = draining ? '0 : bus.B_flat[i*BITS_AB +: BITS_AB];
      end
   end

   for (genvar gi = 0; gi < DIM; gi++) begin : g_skew
      if (gi == 0) begin : g_direct
         assign a_sk[0] = a_edge[0];
         assign b_sk[0] = b_edge[0];
      end else begin : g_dly
         logic signed [BITS_AB-1:0] sa [gi];
         logic signed [BITS_AB-1:0] sb [gi];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < gi; k++) begin
                  sa[k] <= '0;
                  sb[k] <= '0;
               end
            end else if (adv) begin
               sa[0] <= a_edge[gi];
               sb[0] <= b_edge[gi];
               for (int k = 1; k < gi; k++) begin
                  sa[k] <= sa[k-1];
                  sb[k] <= sb[k-1];
               end
            end
         end
         assign a_sk[gi] = sa[gi-1];
         assign b_sk[gi] = sb[gi-1];
      end
   end

   logic signed [BITS_AB-1:0] a_reg  [DIM][DIM];
   logic signed [BITS_AB-1:0] b_reg  [DIM][DIM];
   logic signed [BITS_AB-1:0] a_in   [DIM][DIM];
   logic signed [BITS_AB-1:0] b_in   [DIM][DIM];
   logic signed [BITS_C-1:0]  acc    [DIM][DIM];
   logic signed [BITS_C-1:0]  acc_nx [DIM][DIM];

   // A travels right along rows, B travels down columns
   always_comb begin
      for (int unsigned i = 0; i < DIM; i++) begin
         a_in[i][0] = a_sk[i];
         b_in[0][i] = b_sk[i];
         for (int unsigned j = 1; j < DIM; j++) begin
            a_in[i][j] = a_reg[i][j-1];
            b_in[j][i] = b_reg[j-1][i];
         end
      end
   end

   // clr, then preload, form the base that an accepted beat accumulates onto
   always_comb begin
      for (int unsigned i = 0; i < DIM; i++) begin
         for (int unsigned j = 0; j < DIM; j++) begin
            logic signed [BITS_C-1:0] base;
            if (clr_go)
               base = '0;
            else if (wr_go && bus.Crow == ROW_W'(i))
               base = bus.Cin_flat[j*BITS_C +: BITS_C];
            else
               base = acc[i][j];
            acc_nx[i][j] = adv ? mac(base, a_in[i][j], b_in[i][j]) : base;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DIM; i++) begin
            for (int unsigned j = 0; j < DIM; j++) begin
               a_reg[i][j] <= '0;
               b_reg[i][j] <= '0;
               acc[i][j]   <= '0;
            end
         end
         cout_q <= '0;
      end else begin
         for (int unsigned i = 0; i < DIM; i++) begin
            for (int unsigned j = 0; j < DIM; j++) begin
               if (adv) begin
                  a_reg[i][j] <= a_in[i][j];
                  b_reg[i][j] <= b_in[i][j];
               end
               acc[i][j] <= acc_nx[i][j];
            end
         end
         for (int unsigned j = 0; j < DIM; j++)
            cout_q[j*BITS_C +: BITS_C] <= row_ok ? acc[bus.Crow][j] : '0;
      end
   end
endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array: DIM=2 and DIM=4 instances, wrap or SYSTOLIC_MAC_SAT_EN build.
module tb_systolic_mac_array;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   systolic_mac_array_if #(.BITS_AB(8), .BITS_C(16), .DIM(2)) bus2 ();
   systolic_mac_array_if #(.BITS_AB(8), .BITS_C(16), .DIM(4)) bus4 ();

   systolic_mac_array #(.BITS_AB(8), .BITS_C(16), .DIM(2)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));
   systolic_mac_array #(.BITS_AB(8), .BITS_C(16), .DIM(4)) u4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   always #5 clk = ~clk;

`ifdef SYSTOLIC_MAC_SAT_EN
   localparam int POS3 = 32767;
   localparam int NEG3 = -32768;
`else
   localparam int POS3 = -17149;
   localparam int NEG3 = 16768;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic clr2();
      bus2.clr = 1'b1; tick(); bus2.clr = 1'b0;
   endtask

   task automatic clr4();
      bus4.clr = 1'b1; tick(); bus4.clr = 1'b0;
   endtask

   task automatic beat2(input int a0, input int a1, input int b0, input int b1, input bit last);
      bus2.in_valid = 1'b1;
      bus2.in_last  = last;
      bus2.A_flat   = {8'(a1), 8'(a0)};
      bus2.B_flat   = {8'(b1), 8'(b0)};
      tick();
      bus2.in_valid = 1'b0;
      bus2.in_last  = 1'b0;
   endtask

   task automatic beat4(input int a, input int b, input bit last);
      bus4.in_valid = 1'b1;
      bus4.in_last  = last;
      bus4.A_flat   = {4{8'(a)}};
      bus4.B_flat   = {4{8'(b)}};
      tick();
      bus4.in_valid = 1'b0;
      bus4.in_last  = 1'b0;
   endtask

   task automatic row2(input string tag, input int r, input int e0, input int e1);
      bus2.Crow = 1'(r);
      tick();
      chk({tag, "_c0"}, bus2.Cout[15:0],  16'(e0));
      chk({tag, "_c1"}, bus2.Cout[31:16], 16'(e1));
   endtask

   task automatic row4(input string tag, input int r, input int e);
      bus4.Crow = 2'(r);
      tick();
      chk({tag, "_c0"}, bus4.Cout[15:0],  16'(e));
      chk({tag, "_c3"}, bus4.Cout[63:48], 16'(e));
   endtask

   task automatic wait_done2(input string tag);
      int n = 0;
      while (bus2.done !== 1'b1 && n < 40) begin tick(); n++; end
      chk(tag, 16'(bus2.done), 16'd1);
   endtask

   task automatic wait_done4(input string tag);
      int n = 0;
      while (bus4.done !== 1'b1 && n < 40) begin tick(); n++; end
      chk(tag, 16'(bus4.done), 16'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      {bus2.clr, bus2.in_valid, bus2.in_last, bus2.WrEn} = '0;
      {bus4.clr, bus4.in_valid, bus4.in_last, bus4.WrEn} = '0;
      bus2.A_flat = '0; bus2.B_flat = '0; bus2.Cin_flat = '0; bus2.Crow = '0;
      bus4.A_flat = '0; bus4.B_flat = '0; bus4.Cin_flat = '0; bus4.Crow = '0;
      rst = 1'b1;
      #12;
      chk("rst_ready", 16'(bus2.in_ready), 16'd1);
      chk("rst_busy",  16'(bus2.busy),     16'd0);
      chk("rst_done",  16'(bus2.done),     16'd0);
      chk("rst_cout",  bus2.Cout[15:0],    16'd0);
      @(negedge clk) rst = 1'b0;
      tick();

      // Basic 2x2 product and drain timing
      clr2();
      beat2(1, 3, 5, 6, 1'b0);
      beat2(2, 4, 7, 8, 1'b1);
      chk("t1_ready_drain", 16'(bus2.in_ready), 16'd0);
      chk("t1_busy_drain",  16'(bus2.busy),     16'd1);
      tick();
      chk("t1_done_early",  16'(bus2.done),     16'd0);
      tick();
      chk("t1_done",        16'(bus2.done),     16'd1);
      chk("t1_busy_done",   16'(bus2.busy),     16'd0);
      row2("t1_r0", 0, 19, 22);
      row2("t1_r1", 1, 43, 50);

      // Bubbles between beats
      clr2();
      beat2(1, 3, 5, 6, 1'b0);
      repeat (3) tick();
      chk("t2_busy_bubble", 16'(bus2.busy), 16'd1);
      beat2(2, 4, 7, 8, 1'b1);
      tick();
      chk("t2_done_early", 16'(bus2.done), 16'd0);
      tick();
      chk("t2_done",       16'(bus2.done), 16'd1);
      row2("t2_r0", 0, 19, 22);
      row2("t2_r1", 1, 43, 50);

      // K-tiling from DONE, then clr
      beat2(1, 3, 5, 6, 1'b0);
      beat2(2, 4, 7, 8, 1'b1);
      wait_done2("t3_wait");
      row2("t3_r0", 0, 38, 44);
      row2("t3_r1", 1, 86, 100);
      clr2();
      chk("t3_clr_done", 16'(bus2.done), 16'd0);
      chk("t3_clr_busy", 16'(bus2.busy), 16'd0);
      row2("t3_z0", 0, 0, 0);
      row2("t3_z1", 1, 0, 0);

      // Preload then identity stream; WrEn during DRAIN ignored
      bus2.Crow = 1'b1;
      bus2.Cin_flat = {16'(-100), 16'(100)};
      bus2.WrEn = 1'b1; tick(); bus2.WrEn = 1'b0;
      row2("t4_pre", 1, 100, -100);
      beat2(1, 0, 1, 0, 1'b0);
      beat2(0, 1, 0, 1, 1'b1);
      bus2.Crow = 1'b0;
      bus2.Cin_flat = {16'd77, 16'd77};
      bus2.WrEn = 1'b1; tick(); bus2.WrEn = 1'b0;
      wait_done2("t4_wait");
      row2("t4_r0", 0, 1, 0);
      row2("t4_r1", 1, 100, -99);

      // DIM=4 overflow behaviour
      clr4();
      beat4(127, 127, 1'b0);
      beat4(127, 127, 1'b0);
      beat4(127, 127, 1'b1);
      wait_done4("t5_wait_pos");
      row4("t5_pos_r0", 0, POS3);
      row4("t5_pos_r3", 3, POS3);
      clr4();
      beat4(-128, 127, 1'b0);
      beat4(-128, 127, 1'b0);
      beat4(-128, 127, 1'b1);
      wait_done4("t5_wait_neg");
      row4("t5_neg_r2", 2, NEG3);

      // Async reset in DRAIN
      clr2();
      bus2.Crow = 1'b0;
      beat2(1, 3, 5, 6, 1'b0);
      beat2(2, 4, 7, 8, 1'b1);
      tick();
      rst = 1'b1;
      #2;
      chk("t6_cout0", bus2.Cout[15:0],  16'd0);
      chk("t6_cout1", bus2.Cout[31:16], 16'd0);
      chk("t6_busy",  16'(bus2.busy),     16'd0);
      chk("t6_done",  16'(bus2.done),     16'd0);
      chk("t6_ready", 16'(bus2.in_ready), 16'd1);
      @(negedge clk) rst = 1'b0;
      tick();
      clr2();
      beat2(1, 3, 5, 6, 1'b0);
      beat2(2, 4, 7, 8, 1'b1);
      wait_done2("t6_wait");
      row2("t6_r0", 0, 19, 22);
      row2("t6_r1", 1, 43, 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
